// File: rtl/traffic_pkg.sv
// Shared light encodings and request-FSM state type for the highway/country
// traffic-light controller and its upstream request conditioner.
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    REQ   = 3'd2,
    SERVE = 3'd3,
    DROP  = 3'd4
  } req_state_e;

  // States in which the controller is being asked to give country green.
  function automatic logic req_active(input req_state_e s);
    return (s == REQ) || (s == SERVE);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter; the clean output only
// follows the synchronised input after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             clean_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  // Any agreeing sample restarts the count, so a short glitch never accumulates.
  always_comb begin
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = ~clean_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/country_request_conditioner.sv
// Turns the country-road loop sensor into the controller's request input x,
// holding off for a minimum highway green and capping the country green dwell.
module country_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_HWY_GREEN   = 16,
  parameter int MAX_CTRY_GREEN  = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sensor_raw,
  input  logic [2:0] highway,
  input  logic [2:0] country,
  output logic       x,
  output logic       car_present,
  output logic       pending
);

  localparam logic [CNT_W-1:0] HWY_SAT  = CNT_W'(MIN_HWY_GREEN);
  localparam logic [CNT_W-1:0] CTRY_SAT = CNT_W'(MAX_CTRY_GREEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  req_state_e       state_q;
  req_state_e       state_d;
  logic [CNT_W-1:0] hwy_cnt_q;
  logic [CNT_W-1:0] hwy_cnt_d;
  logic [CNT_W-1:0] ctry_cnt_q;
  logic [CNT_W-1:0] ctry_cnt_d;
  logic             pending_q;
  logic             pending_d;
  logic             x_q;
  logic             car_clean;
  logic             hwy_green;
  logic             ctry_green;
  logic             ctry_red;
  logic             serve_entry;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sensor_raw),
    .clean(car_clean)
  );

  assign hwy_green  = (highway == GREEN);
  assign ctry_green = (country == GREEN);
  assign ctry_red   = (country == RED);

  // Green timers: cleared by any non-green code (including illegal ones),
  // frozen while the controller is stopped, and saturating at their limit.
  always_comb begin
    hwy_cnt_d  = hwy_cnt_q;
    ctry_cnt_d = ctry_cnt_q;
    if (!hwy_green) begin
      hwy_cnt_d = '0;
    end else if (en && (hwy_cnt_q < HWY_SAT)) begin
      hwy_cnt_d = hwy_cnt_q + CNT_ONE;
    end
    if (!ctry_green) begin
      ctry_cnt_d = '0;
    end else if (en && (ctry_cnt_q < CTRY_SAT)) begin
      ctry_cnt_d = ctry_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        IDLE:    if (pending_q) state_d = WAIT;
        WAIT:    if (hwy_green && (hwy_cnt_q >= HWY_SAT)) state_d = REQ;
        REQ:     if (ctry_green) state_d = SERVE;
        SERVE:   if (!car_clean || (ctry_cnt_q >= CTRY_SAT)) state_d = DROP;
        DROP:    if (ctry_red) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign serve_entry = (state_q == REQ) && (state_d == SERVE);

  // Set only under country red and cleared only on entry to SERVE (country
  // green), so the two never compete.
  always_comb begin
    pending_d = pending_q;
    if (car_clean && ctry_red) begin
      pending_d = 1'b1;
    end else if (serve_entry) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hwy_cnt_q  <= '0;
      ctry_cnt_q <= '0;
      pending_q  <= 1'b0;
      x_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      hwy_cnt_q  <= hwy_cnt_d;
      ctry_cnt_q <= ctry_cnt_d;
      pending_q  <= pending_d;
      x_q        <= req_active(state_d);
    end
  end

  assign x           = x_q;
  assign car_present = car_clean;
  assign pending     = pending_q;

endmodule

// File: tb/tb_country_request_conditioner.sv
// Scenario bench for the country request conditioner: the bench plays the light
// controller and schedules expected output values per cycle on a scoreboard queue.
module tb_country_request_conditioner;
  import traffic_pkg::*;

  localparam int SEL_X    = 0;
  localparam int SEL_CAR  = 1;
  localparam int SEL_PEND = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       sensorRaw;
  logic [2:0] highway;
  logic [2:0] country;
  logic       x;
  logic       carPresent;
  logic       pending;

  typedef struct {
    int    cyc;
    string tag;
    int    sel;
    logic  want;
  } expEntry_t;

  expEntry_t sbQueue[$];
  int cycleCount   = 0;
  int compareCount = 0;
  int failCount    = 0;

  country_request_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .MIN_HWY_GREEN  (16),
    .MAX_CTRY_GREEN (8),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sensor_raw (sensorRaw),
    .highway    (highway),
    .country    (country),
    .x          (x),
    .car_present(carPresent),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount = cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] hwy, input logic [2:0] ctry,
                               input logic enable, input logic sensor);
    highway   = hwy;
    country   = ctry;
    en        = enable;
    sensorRaw = sensor;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectRange(input int c0, input int c1, input string tag,
                             input int sel, input logic want);
    for (int c = c0; c <= c1; c++) begin
      sbQueue.push_back('{cyc: c, tag: tag, sel: sel, want: want});
    end
  endtask

  function automatic logic observe(input int sel);
    case (sel)
      SEL_X:   return x;
      SEL_CAR: return carPresent;
      default: return pending;
    endcase
  endfunction

  // Outputs settle after the rising edge; compare every entry due this cycle.
  always @(negedge clk) begin
    for (int i = sbQueue.size() - 1; i >= 0; i--) begin
      if (sbQueue[i].cyc == cycleCount) begin
        checkOutput($sformatf("%s@%0d", sbQueue[i].tag, cycleCount),
                    {31'b0, observe(sbQueue[i].sel)}, {31'b0, sbQueue[i].want});
        sbQueue.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int m;
    int h;
    int r;

    rst_n = 1'b0;
    applyStimulus(GREEN, RED, 1'b1, 1'b0);
    #1;
    checkOutput("reset_x", {31'b0, x}, 32'd0);
    checkOutput("reset_car", {31'b0, carPresent}, 32'd0);
    checkOutput("reset_pend", {31'b0, pending}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(20);

    // Three-cycle pulse must never reach car_present.
    n = cycleCount;
    applyStimulus(GREEN, RED, 1'b1, 1'b1);
    expectRange(n + 1, n + 12, "glitch_x", SEL_X, 1'b0);
    expectRange(n + 1, n + 12, "glitch_car", SEL_CAR, 1'b0);
    expectRange(n + 1, n + 12, "glitch_pend", SEL_PEND, 1'b0);
    tick(3);
    applyStimulus(GREEN, RED, 1'b1, 1'b0);
    tick(10);

    // Arrival on a long highway green: +6 car, +7 pending, +9 request.
    n = cycleCount;
    applyStimulus(GREEN, RED, 1'b1, 1'b1);
    expectRange(n + 1, n + 5, "arr_car", SEL_CAR, 1'b0);
    expectRange(n + 6, n + 6, "arr_car", SEL_CAR, 1'b1);
    expectRange(n + 1, n + 6, "arr_pend", SEL_PEND, 1'b0);
    expectRange(n + 7, n + 7, "arr_pend", SEL_PEND, 1'b1);
    expectRange(n + 1, n + 8, "arr_x", SEL_X, 1'b0);
    expectRange(n + 9, n + 9, "arr_x", SEL_X, 1'b1);
    tick(9);

    // Car stays through country green: request dropped by the dwell cap.
    applyStimulus(YELLOW, RED, 1'b1, 1'b1);
    expectRange(n + 10, n + 18, "cap_x", SEL_X, 1'b1);
    expectRange(n + 19, n + 19, "cap_x", SEL_X, 1'b0);
    expectRange(n + 10, n + 10, "cap_pend", SEL_PEND, 1'b1);
    expectRange(n + 11, n + 19, "cap_pend", SEL_PEND, 1'b0);
    expectRange(n + 10, n + 19, "cap_car", SEL_CAR, 1'b1);
    tick(1);
    applyStimulus(RED, GREEN, 1'b1, 1'b1);
    tick(9);

    // Back to country red with the car still waiting: re-arm and wait out min green.
    applyStimulus(RED, YELLOW, 1'b1, 1'b1);
    expectRange(n + 20, n + 20, "rearm_pend", SEL_PEND, 1'b0);
    expectRange(n + 21, n + 37, "rearm_pend", SEL_PEND, 1'b1);
    expectRange(n + 20, n + 36, "rearm_x", SEL_X, 1'b0);
    expectRange(n + 37, n + 37, "rearm_x", SEL_X, 1'b1);
    tick(1);
    applyStimulus(GREEN, RED, 1'b1, 1'b1);
    tick(17);

    // Car leaves early in country green: x falls the edge after car_present.
    m = cycleCount;
    applyStimulus(YELLOW, RED, 1'b1, 1'b1);
    expectRange(m + 1, m + 8, "leave_x", SEL_X, 1'b1);
    expectRange(m + 9, m + 9, "leave_x", SEL_X, 1'b0);
    expectRange(m + 1, m + 1, "leave_pend", SEL_PEND, 1'b1);
    expectRange(m + 2, m + 9, "leave_pend", SEL_PEND, 1'b0);
    expectRange(m + 1, m + 7, "leave_car", SEL_CAR, 1'b1);
    expectRange(m + 8, m + 8, "leave_car", SEL_CAR, 1'b0);
    tick(1);
    applyStimulus(RED, GREEN, 1'b1, 1'b1);
    tick(1);
    applyStimulus(RED, GREEN, 1'b1, 1'b0);
    tick(7);

    // Min-green hold with a 5-cycle enable freeze pushing x out by 5.
    applyStimulus(RED, YELLOW, 1'b1, 1'b0);
    tick(1);
    h = cycleCount;
    applyStimulus(GREEN, RED, 1'b1, 1'b0);
    expectRange(h + 7, h + 7, "hold_car", SEL_CAR, 1'b0);
    expectRange(h + 8, h + 8, "hold_car", SEL_CAR, 1'b1);
    expectRange(h + 1, h + 8, "hold_pend", SEL_PEND, 1'b0);
    expectRange(h + 9, h + 22, "hold_pend", SEL_PEND, 1'b1);
    expectRange(h + 1, h + 21, "hold_x", SEL_X, 1'b0);
    expectRange(h + 22, h + 22, "hold_x", SEL_X, 1'b1);
    tick(2);
    applyStimulus(GREEN, RED, 1'b1, 1'b1);
    tick(9);
    applyStimulus(GREEN, RED, 1'b0, 1'b1);
    tick(5);
    applyStimulus(GREEN, RED, 1'b1, 1'b1);
    tick(6);

    // Reset asserted while serving: outputs clear at once, FSM restarts idle.
    applyStimulus(YELLOW, RED, 1'b1, 1'b1);
    expectRange(h + 23, h + 24, "serve_x", SEL_X, 1'b1);
    tick(1);
    applyStimulus(RED, GREEN, 1'b1, 1'b1);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_x", {31'b0, x}, 32'd0);
    checkOutput("midrst_car", {31'b0, carPresent}, 32'd0);
    checkOutput("midrst_pend", {31'b0, pending}, 32'd0);
    tick(2);
    r = cycleCount;
    rst_n = 1'b1;
    expectRange(r + 1, r + 12, "post_x", SEL_X, 1'b0);
    expectRange(r + 1, r + 12, "post_pend", SEL_PEND, 1'b0);
    expectRange(r + 1, r + 5, "post_car", SEL_CAR, 1'b0);
    expectRange(r + 6, r + 6, "post_car", SEL_CAR, 1'b1);
    tick(12);

    // From IDLE, a red country light re-arms the request; highway not green keeps x low.
    applyStimulus(RED, RED, 1'b1, 1'b1);
    expectRange(r + 13, r + 16, "idle_pend", SEL_PEND, 1'b1);
    expectRange(r + 13, r + 16, "idle_x", SEL_X, 1'b0);
    tick(6);

    checkOutput("sb_drain", sbQueue.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
